// File: rtl/toy_uart_pkg.sv
// toy_uart_pkg: definitions shared by the toy UART blocks.
//   uart_state_t      - character framing FSM states (also used by the TX side)
//   DATA_BITS         - data bits per character (8N1)
//   STOP_BITS         - stop bits per character (8N1)
package toy_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

endpackage

// File: rtl/toy_uart_rx_if.sv
// toy_uart_rx_if: byte output channel of the UART receiver.
//   o_data      - received byte, valid while o_valid is high
//   o_valid     - holding register full
//   i_ready     - consumer accepts the byte when o_valid & i_ready
//   o_frame_err - one-cycle pulse, stop bit was low and the byte was discarded
//   o_overrun   - one-cycle pulse, a byte arrived while the holder was full
// Modports: master = receiver side, slave = consumer side.
interface toy_uart_rx_if
  import toy_uart_pkg::*;
;

  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_frame_err;
  logic                 o_overrun;

  modport master (
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_overrun,
    input  i_ready
  );

  modport slave (
    input  o_data,
    input  o_valid,
    input  o_frame_err,
    input  o_overrun,
    output i_ready
  );

endinterface

// File: rtl/toy_sync2.sv
// toy_sync2: generic two-flop synchroniser for signals crossing into clk.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, both flops load RESET_VAL
//   d     - asynchronous input
//   q     - synchronised output (two clk cycles of latency)
module toy_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/toy_uart_rx.sv
// toy_uart_rx: 8N1 UART receiver with a one-entry valid/ready holding register.
//   BAUD_DIV  - clock cycles per bit (>= 4)
//   i_clk     - sole clock, rising edge
//   i_nrst    - asynchronous active-low reset
//   i_uart_rx - raw serial line, idle high, asynchronous to i_clk
//   bus       - byte output channel (o_data/o_valid/i_ready/o_frame_err/o_overrun)
module toy_uart_rx
  import toy_uart_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic          i_uart_rx,
  toy_uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int HALF  = BAUD_DIV / 2;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_state_t          state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [2:0]           idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 deliver;
  logic                 frame_err_next;

  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg;
  logic                 frame_err_reg;
  logic                 overrun_reg;

  toy_sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (i_clk),
    .rst_n (i_nrst),
    .d     (i_uart_rx),
    .q     (rx_s)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + CNT_W'(1);
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    deliver        = 1'b0;
    frame_err_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (!rx_s) begin
          state_next = ST_START;
        end
      end

      // Re-check the start bit at its midpoint; a line that is high again
      // there was only a glitch.
      ST_START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next = ST_DATA;
            idx_next   = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end

      // Line order is LSB first, so shifting in at the MSB leaves bit 0 in
      // position 0 after the eighth sample.
      ST_DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
          if (idx_reg == IDX_LAST) begin
            state_next = ST_STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
      end

      ST_STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = ST_BREAK;
          end
        end
      end

      // A line held low after a bad stop bit must not be framed again until
      // it has returned to idle.
      ST_BREAK: begin
        cnt_next = '0;
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Holding register. A delivery into a full holder only succeeds when the
  // consumer drains it in the very same cycle; otherwise the new byte is lost.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= frame_err_next;
      overrun_reg   <= 1'b0;
      if (deliver) begin
        if (!valid_reg || bus.i_ready) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (valid_reg && bus.i_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign bus.o_data      = data_reg;
  assign bus.o_valid     = valid_reg;
  assign bus.o_frame_err = frame_err_reg;
  assign bus.o_overrun   = overrun_reg;

endmodule
